odd_parity_frame_checker: RTL and testbench
===========================================

ODD_PARITY_FRAME_CHECKER -- requirements
Module: odd_parity_frame_checker

Interface
REQ-001 Parameter: DATA_W, default 4, number of data bits per frame.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: bit_en  input  1  one-cycle strobe; sdi is sampled only when high.
REQ-005 Port: sdi  input  1  serial line, idle high.
REQ-006 Port: data_out  output  DATA_W  received data; first-received bit lands in the MSB.
REQ-007 Port: out_valid  output  1  one-cycle pulse; frame result is valid.
REQ-008 Port: parity_err  output  1  received parity bit fails the odd check; qualified by out_valid.
REQ-009 Port: frame_err  output  1  stop bit sampled low; qualified by out_valid.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be: start bit (0), DATA_W data bits, parity bit, stop bit (1). Each bit is one bit_en sample.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-013 IDLE: when bit_en=1 and sdi=0, go to DATA and clear the bit counter. sdi=1 keeps the FSM in IDLE.
REQ-014 DATA: on each bit_en, shift sdi into the LSB of the shift register and increment the counter. After the DATA_W-th bit, go to PARITY.
REQ-015 PARITY: on bit_en, capture sdi and go to STOP.
REQ-016 STOP: on bit_en, go to IDLE. The next cycle, pulse out_valid, load data_out and set both error flags.
REQ-017 Odd-parity rule: parity_err=1 iff XOR of the DATA_W data bits and the parity bit equals 0.
REQ-018 frame_err=1 iff the stop sample is 0. The frame is still reported: data_out and parity_err stay meaningful.
REQ-019 Latency: out_valid SHALL be exactly 1 clk after the bit_en cycle that samples the stop bit.
REQ-020 Cycles with bit_en=0 SHALL hold all state. There is no timeout.
REQ-021 data_out, parity_err and frame_err SHALL hold their values until the next out_valid.
REQ-022 Back-to-back frames: a start bit sampled in the cycle right after stop, while out_valid is high, SHALL be accepted.
REQ-023 Bit counter width: $clog2(DATA_W+1). DATA_W < 1 is illegal.

Reset
REQ-024 Synchronous reset SHALL put the FSM in IDLE and zero the counter, shift register, data_out, out_valid, parity_err, frame_err and busy.
REQ-025 Reset mid-frame SHALL abort the frame with no out_valid. Reset has priority over bit_en.

Configuration
REQ-026 Macro ODD_PARITY_ERR_CNT_EN, when defined, SHALL add output err_cnt [7:0].
  - err_cnt increments on each out_valid with parity_err or frame_err set.
  - It saturates at 255 and is cleared by rst.
REQ-027 Without the macro, err_cnt and its logic SHALL be absent and all other behaviour stays identical.

Structure
REQ-028 A shared package odd_parity_pkg SHALL hold:
  - the FSM state enum;
  - the default DATA_W constant;
  - the odd-parity function, which is reused by the upstream generator.
REQ-029 There is one sub-module, odd_parity_shift_reg: a DATA_W-bit shift register with enable and synchronous clear. The FSM and checking logic stay in the top.

Verification
REQ-030 Frame 0,1,0,1,0,1,1 (data 4'b1010, parity 1, stop 1) -> out_valid 1 clk after stop; data_out=4'b1010, parity_err=0, frame_err=0.
REQ-031 Frame 0,0,1,1,1,1,1 (data 4'b0111, parity 1) -> data_out=4'b0111, parity_err=1, frame_err=0.
REQ-032 Frame 0,0,0,0,0,1,0 (data 4'b0000, parity 1, stop 0) -> data_out=4'b0000, parity_err=0, frame_err=1.
REQ-033 bit_en every 3rd cycle with the REQ-030 frame -> same result, out_valid pulses once, busy high from the start sample to the stop sample.
REQ-034 rst asserted after the 2nd data bit, then a full REQ-031 frame -> no out_valid for the aborted frame; the second frame reports correctly.
REQ-035 Two frames back-to-back (REQ-030 then REQ-032, no idle bits) -> two out_valid pulses with the correct flags. With ODD_PARITY_ERR_CNT_EN, err_cnt ends at 1.

Source files
------------

// File: rtl/odd_parity_pkg.sv
// Shared types, defaults and the odd-parity helper for the frame checker and its generator.
package odd_parity_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned DEFAULT_DATA_W = 4;

    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int unsigned PARITY_MAX_W = 32;

    // Parity bit that makes the total number of ones (data + parity) odd.
    function automatic logic odd_parity_bit(input logic [PARITY_MAX_W-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/odd_parity_shift_reg.sv
// DATA_W-bit left shift register (serial in at the LSB) with enable and synchronous clear.
module odd_parity_shift_reg #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            if (DATA_W == 1) begin
                sr_d = DATA_W'(d_i);
            end else begin
                sr_d = {sr_q[DATA_W-2:0], d_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/odd_parity_frame_checker.sv
// Serial frame receiver (start, DATA_W data MSB-first, odd parity, stop) with error flags.
// Optional saturating error counter output err_cnt when ODD_PARITY_ERR_CNT_EN is defined.
module odd_parity_frame_checker
    import odd_parity_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sdi,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef ODD_PARITY_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               parity_q;
    logic [DATA_W-1:0]  data_out_q;
    logic               out_valid_q;
    logic               parity_err_q;
    logic               frame_err_q;
    logic               busy_q;

    logic [DATA_W-1:0]  sr_q;
    logic               start_seen;
    logic               shift_en;
    logic               parity_bad;

    assign start_seen = bit_en && (state_q == StIdle) && !sdi;
    assign shift_en   = bit_en && (state_q == StData);
    assign parity_bad = (odd_parity_bit(PARITY_MAX_W'(sr_q)) != parity_q);

    // Cleared on every accepted start so a stale frame never leaks into the next one.
    odd_parity_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk_i (clk),
        .clr_i (rst || start_seen),
        .en_i  (shift_en),
        .d_i   (sdi),
        .q_o   (sr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            parity_q     <= 1'b0;
            data_out_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bit_en) begin
                unique case (state_q)
                    StIdle: begin
                        if (!sdi) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    StData: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_q <= sdi;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        out_valid_q  <= 1'b1;
                        data_out_q   <= sr_q;
                        parity_err_q <= parity_bad;
                        frame_err_q  <= !sdi;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_q;
    assign out_valid  = out_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

`ifdef ODD_PARITY_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (out_valid_q && (parity_err_q || frame_err_q) && (err_cnt_q != 8'hff)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_odd_parity_frame_checker.sv
// Self-checking bench for odd_parity_frame_checker: directed frames plus random frames
// compared against a frame-level reference model.
module tb_odd_parity_frame_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_en = 1'b0;
    logic         sdi = 1'b1;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;
`ifdef ODD_PARITY_ERR_CNT_EN
    logic [7:0]   err_cnt;
`endif

    odd_parity_frame_checker #(
        .DATA_W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sdi        (sdi),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef ODD_PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected results queued per frame, consumed at each out_valid.
    typedef struct packed {
        logic [W-1:0] data;
        logic         perr;
        logic         ferr;
    } result_t;

    result_t      exp_q[$];
    result_t      last_res = '0;
    int           n_pulses = 0;
    int           exp_errs = 0;
    bit           mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    last_res = exp_q.pop_front();
                    check_eq("data_out", 32'(data_out), 32'(last_res.data));
                    check_eq("parity_err", 32'(parity_err), 32'(last_res.perr));
                    check_eq("frame_err", 32'(frame_err), 32'(last_res.ferr));
                end
            end else begin
                check_eq("hold_data", 32'(data_out), 32'(last_res.data));
                check_eq("hold_flags", 32'({parity_err, frame_err}),
                         32'({last_res.perr, last_res.ferr}));
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; sdi is junk while bit_en is low.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit_en = 1'b0;
            sdi    = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_bit(input logic b, input logic exp_busy, input int gap);
        bit_en = 1'b1;
        sdi    = b;
        @(posedge clk);
        #1;
        check_eq("busy", 32'(busy), 32'(exp_busy));
        for (int i = 0; i < gap; i++) begin
            bit_en = 1'b0;
            sdi    = 1'($urandom);
            @(posedge clk);
            #1;
            check_eq("busy_hold", 32'(busy), 32'(exp_busy));
        end
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic par, input logic stop,
                              input int gap);
        result_t r;
        r.data = data;
        r.perr = (($countones(data) + int'(par)) % 2) == 0;
        r.ferr = !stop;
        if (r.perr || r.ferr) exp_errs++;
        sample_bit(1'b0, 1'b1, gap);
        for (int i = W - 1; i >= 0; i--) sample_bit(data[i], 1'b1, gap);
        sample_bit(par, 1'b1, gap);
        exp_q.push_back(r);
        bit_en = 1'b1;
        sdi    = stop;
        @(posedge clk);
        #1;
        check_eq("latency_valid", 32'(out_valid), 32'd1);
        check_eq("busy_after_stop", 32'(busy), 32'd0);
        bit_en = 1'b0;
        sdi    = 1'b1;
        idle_cycles(gap);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bit_en = 1'b1;
        sdi    = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        bit_en = 1'b0;
        sdi    = 1'b1;
        exp_q.delete();
        last_res = '0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_flags", 32'({parity_err, frame_err}), 32'd0);
`ifdef ODD_PARITY_ERR_CNT_EN
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    endtask

    initial begin
        int p0;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;
        idle_cycles(3);

        // Basic frames with contiguous bit_en.
        send_frame(4'b1010, 1'b1, 1'b1, 0);
        idle_cycles(2);
        send_frame(4'b0111, 1'b1, 1'b1, 0);
        idle_cycles(2);
        send_frame(4'b0000, 1'b1, 1'b0, 0);
        idle_cycles(2);

        // Slow strobe: one bit_en every third cycle, exactly one pulse.
        p0 = n_pulses;
        send_frame(4'b1010, 1'b1, 1'b1, 2);
        idle_cycles(3);
        check_eq("slow_pulses", 32'(n_pulses - p0), 32'd1);

        // Idle-high samples must not start a frame.
        for (int i = 0; i < 3; i++) sample_bit(1'b1, 1'b0, 0);

        // Abort after the second data bit, then a full frame.
        p0 = n_pulses;
        sample_bit(1'b0, 1'b1, 0);
        sample_bit(1'b0, 1'b1, 0);
        sample_bit(1'b1, 1'b1, 0);
        do_reset();
        idle_cycles(8);
        check_eq("abort_no_valid", 32'(n_pulses - p0), 32'd0);
        exp_errs = 0;
        send_frame(4'b0111, 1'b1, 1'b1, 0);
        idle_cycles(2);

        // Back-to-back frames, start sampled while out_valid is high.
        p0 = n_pulses;
        send_frame(4'b1010, 1'b1, 1'b1, 0);
        send_frame(4'b0000, 1'b1, 1'b0, 0);
        idle_cycles(2);
        check_eq("b2b_pulses", 32'(n_pulses - p0), 32'd2);
`ifdef ODD_PARITY_ERR_CNT_EN
        check_eq("err_cnt_b2b", 32'(err_cnt), 32'(exp_errs));
`endif

        // Random frames with random strobe spacing and idle samples between them.
        for (int f = 0; f < 40; f++) begin
            logic [W-1:0] d;
            logic         par;
            logic         stop;
            d    = W'($urandom);
            par  = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            for (int k = $urandom_range(0, 2); k > 0; k--) sample_bit(1'b1, 1'b0, 0);
            send_frame(d, par, stop, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(4);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef ODD_PARITY_ERR_CNT_EN
        check_eq("err_cnt_final", 32'(err_cnt), 32'((exp_errs > 255) ? 255 : exp_errs));
`endif

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
